// File: rtl/xgmii_tx_framer.sv
// 32-bit AXI-Stream to XGMII transmit framer: Start/preamble/SFD, data, Terminate, inter-packet gap.
// Optional build macro TX_PAD_EN zero-pads short frames to 60 payload bytes before Terminate.
module xgmii_tx_framer #(
   parameter int IPG_WORDS = 3
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] s_axis_tdata,
   input  logic [3:0]  s_axis_tkeep,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tlast,
   output logic        s_axis_tready,
   input  logic        i_xgmii_tx_ready,
   output logic [31:0] o_xgmii_txd,
   output logic [3:0]  o_xgmii_txc,
   output logic        o_underflow
);

   localparam logic [31:0] IDLE_WORD  = 32'h0707_0707;
   localparam logic [31:0] START_WORD = 32'h5555_55FB;
   localparam logic [31:0] SFD_WORD   = 32'hD555_5555;
   localparam logic [31:0] TERM_WORD  = 32'h0707_07FD;
   localparam logic [31:0] ERR_WORD   = 32'hFEFE_FEFE;
   localparam logic [3:0]  IPG_LAST   = 4'(IPG_WORDS - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_PRE0,
      S_PRE1,
      S_DATA,
      S_TERM,
      S_ABORT,
      S_DRAIN,
      S_IPG,
      S_PAD
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] txd_nxt;
   logic [3:0]  txc_nxt;
   logic        underflow_nxt;
   logic [3:0]  ipg_cnt, ipg_nxt;
   logic [2:0]  n_keep;
   logic [31:0] term_txd;
   logic [3:0]  term_txc;
   logic        pad_short;

   function automatic logic [2:0] keep_count(input logic [3:0] keep);
      case (keep)
         4'b0001: keep_count = 3'd1;
         4'b0011: keep_count = 3'd2;
         4'b0111: keep_count = 3'd3;
         default: keep_count = 3'd4;
      endcase
   endfunction

   assign n_keep = keep_count(s_axis_tkeep);

   // Short tlast word: valid lanes keep data, first empty lane carries FD, the rest idle.
   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      term_txd = s_axis_tdata;
      term_txc = 4'h0;
      for (int l = 0; l < 4; l++) begin
         if (3'(l) == n_keep) begin
            term_txd[l*8 +: 8] = 8'hFD;
            term_txc[l]        = 1'b1;
         end else if (3'(l) > n_keep) begin
            term_txd[l*8 +: 8] = 8'h07;
            term_txc[l]        = 1'b1;
         end
      end
   end

`ifdef TX_PAD_EN
   logic [6:0]  byte_cnt, byte_nxt;
   logic [7:0]  byte_sum, byte_round;
   logic [31:0] keep_mask;

   assign byte_sum   = {1'b0, byte_cnt} + {5'b0, n_keep};
   assign byte_round = (byte_sum + 8'd3) & 8'hFC;
   assign pad_short  = (byte_sum < 8'd60);

   always_comb begin
      keep_mask = '0;
      for (int l = 0; l < 4; l++) keep_mask[l*8 +: 8] = {8{s_axis_tkeep[l]}};
   end
`else
   assign pad_short = 1'b0;
`endif

   assign s_axis_tready = i_xgmii_tx_ready &&
                          (state == S_PRE1 || state == S_DATA || state == S_DRAIN);

   // A pause cycle leaves every next-value at its current value; underflow is a strict pulse.
   always_comb begin
      state_nxt     = state;
      txd_nxt       = o_xgmii_txd;
      txc_nxt       = o_xgmii_txc;
      underflow_nxt = 1'b0;
      ipg_nxt       = ipg_cnt;
`ifdef TX_PAD_EN
      byte_nxt      = byte_cnt;
`endif
      if (i_xgmii_tx_ready) begin
         case (state)
            S_IDLE: begin
               txd_nxt = IDLE_WORD;
               txc_nxt = 4'hF;
`ifdef TX_PAD_EN
               byte_nxt = '0;
`endif
               if (s_axis_tvalid) begin
                  state_nxt = S_PRE0;
                  txd_nxt   = START_WORD;
                  txc_nxt   = 4'h1;
               end
            end
            S_PRE0: begin
               state_nxt = S_PRE1;
               txd_nxt   = SFD_WORD;
               txc_nxt   = 4'h0;
            end
            S_PRE1, S_DATA: begin
               if (!s_axis_tvalid) begin
                  state_nxt     = S_ABORT;
                  txd_nxt       = ERR_WORD;
                  txc_nxt       = 4'hF;
                  underflow_nxt = 1'b1;
               end else begin
                  state_nxt = S_DATA;
                  txd_nxt   = s_axis_tdata;
                  txc_nxt   = 4'h0;
`ifdef TX_PAD_EN
                  byte_nxt  = (byte_sum > 8'd127) ? 7'd127 : byte_sum[6:0];
`endif
                  if (s_axis_tlast) begin
                     if (pad_short) begin
`ifdef TX_PAD_EN
                        txd_nxt   = s_axis_tdata & keep_mask;
                        byte_nxt  = byte_round[6:0];
                        state_nxt = (byte_round >= 8'd60) ? S_TERM : S_PAD;
`endif
                     end else if (n_keep == 3'd4) begin
                        state_nxt = S_TERM;
                     end else begin
                        txd_nxt   = term_txd;
                        txc_nxt   = term_txc;
                        state_nxt = S_IPG;
                        ipg_nxt   = '0;
                     end
                  end
               end
            end
`ifdef TX_PAD_EN
            S_PAD: begin
               txd_nxt  = '0;
               txc_nxt  = 4'h0;
               byte_nxt = byte_cnt + 7'd4;
               if (byte_cnt + 7'd4 >= 7'd60) state_nxt = S_TERM;
            end
`endif
            S_TERM: begin
               state_nxt = S_IPG;
               txd_nxt   = TERM_WORD;
               txc_nxt   = 4'hF;
               ipg_nxt   = '0;
            end
            S_ABORT: begin
               state_nxt = S_DRAIN;
               txd_nxt   = IDLE_WORD;
               txc_nxt   = 4'hF;
            end
            S_DRAIN: begin
               txd_nxt = IDLE_WORD;
               txc_nxt = 4'hF;
               if (s_axis_tvalid && s_axis_tlast) begin
                  state_nxt = S_IPG;
                  ipg_nxt   = '0;
               end
            end
            S_IPG: begin
               txd_nxt = IDLE_WORD;
               txc_nxt = 4'hF;
               if (ipg_cnt == IPG_LAST) begin
                  state_nxt = S_IDLE;
                  ipg_nxt   = '0;
               end else begin
                  ipg_nxt = ipg_cnt + 4'd1;
               end
            end
            default: begin
               state_nxt = S_IDLE;
               txd_nxt   = IDLE_WORD;
               txc_nxt   = 4'hF;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state       <= S_IDLE;
         o_xgmii_txd <= IDLE_WORD;
         o_xgmii_txc <= 4'hF;
         o_underflow <= 1'b0;
         ipg_cnt     <= '0;
`ifdef TX_PAD_EN
         byte_cnt    <= '0;
`endif
      end else begin
         state       <= state_nxt;
         o_xgmii_txd <= txd_nxt;
         o_xgmii_txc <= txc_nxt;
         o_underflow <= underflow_nxt;
         ipg_cnt     <= ipg_nxt;
`ifdef TX_PAD_EN
         byte_cnt    <= byte_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Directed bench for xgmii_tx_framer: reset, back-to-back frames, short tlast, pause, underflow, mid-frame reset.
module tb_xgmii_tx_framer;

   localparam int IPG_WORDS = 3;
`ifdef TX_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   localparam logic [35:0] W_IDLE  = {4'hF, 32'h0707_0707};
   localparam logic [35:0] W_START = {4'h1, 32'h5555_55FB};
   localparam logic [35:0] W_SFD   = {4'h0, 32'hD555_5555};
   localparam logic [35:0] W_TERM  = {4'hF, 32'h0707_07FD};
   localparam logic [35:0] W_ERR   = {4'hF, 32'hFEFE_FEFE};

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic [31:0] s_axis_tdata = '0;
   logic [3:0]  s_axis_tkeep = 4'hF;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tready;
   logic        i_xgmii_tx_ready = 1'b1;
   logic [31:0] o_xgmii_txd;
   logic [3:0]  o_xgmii_txc;
   logic        o_underflow;

   xgmii_tx_framer #(.IPG_WORDS(IPG_WORDS)) dut (
      .i_clk            (i_clk),
      .i_reset          (i_reset),
      .s_axis_tdata     (s_axis_tdata),
      .s_axis_tkeep     (s_axis_tkeep),
      .s_axis_tvalid    (s_axis_tvalid),
      .s_axis_tlast     (s_axis_tlast),
      .s_axis_tready    (s_axis_tready),
      .i_xgmii_tx_ready (i_xgmii_tx_ready),
      .o_xgmii_txd      (o_xgmii_txd),
      .o_xgmii_txc      (o_xgmii_txc),
      .o_underflow      (o_underflow)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      int          gap;
   } beat_t;

   int          n_vec = 0;
   int          n_bad = 0;
   int          n_accepted = 0;
   int          uf_cnt = 0;
   int          cyc = 0;
   bit          pause_en = 1'b0;
   beat_t       beats[$];
   logic [35:0] got_q[$];
   logic [35:0] exp_q[$];

   task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Pause generator: one gearbox slot every 32nd cycle while enabled.
   initial forever begin
      @(posedge i_clk);
      #1;
      cyc++;
      i_xgmii_tx_ready = !(pause_en && (cyc % 32 == 31));
   end

   // Record a word only when the preceding edge was a non-pause edge.
   initial begin
      bit rdy_prev;
      rdy_prev = 1'b0;
      forever begin
         @(negedge i_clk);
         if (rdy_prev) got_q.push_back({o_xgmii_txc, o_xgmii_txd});
         if (o_underflow) uf_cnt++;
         rdy_prev = i_xgmii_tx_ready;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic add_frame(input int nbytes, input logic [7:0] base, input int gap0);
      beat_t b;
      for (int w = 0; w * 4 < nbytes; w++) begin
         b.data = '0;
         b.keep = '0;
         for (int l = 0; l < 4; l++) begin
            if (w * 4 + l < nbytes) begin
               b.data[l*8 +: 8] = base + 8'(w * 4 + l);
               b.keep[l]        = 1'b1;
            end
         end
         b.last = (w * 4 + 4 >= nbytes);
         b.gap  = (w == 0) ? gap0 : 0;
         beats.push_back(b);
      end
   endtask

   task automatic exp_frame(input int nbytes, input logic [7:0] base);
      int          total;
      int          idx;
      logic [35:0] w;
      total = (PAD_EN && nbytes < 60) ? 60 : nbytes;
      exp_q.push_back(W_START);
      exp_q.push_back(W_SFD);
      for (int wi = 0; wi * 4 < total; wi++) begin
         w = '0;
         for (int l = 0; l < 4; l++) begin
            idx = wi * 4 + l;
            if (idx < nbytes) w[l*8 +: 8] = base + 8'(idx);
            else if (idx < total) w[l*8 +: 8] = 8'h00;
            else if (idx == total) begin
               w[l*8 +: 8] = 8'hFD;
               w[32 + l]   = 1'b1;
            end else begin
               w[l*8 +: 8] = 8'h07;
               w[32 + l]   = 1'b1;
            end
         end
         exp_q.push_back(w);
      end
      if (total % 4 == 0) exp_q.push_back(W_TERM);
      repeat (IPG_WORDS) exp_q.push_back(W_IDLE);
   endtask

   // Called just after a posedge; returns just after the edge that accepted the last beat.
   task automatic drive_beats();
      beat_t b;
      bit    acc;
      int    t;
      while (beats.size() > 0) begin
         b = beats.pop_front();
         repeat (b.gap) begin
            s_axis_tvalid = 1'b0;
            @(posedge i_clk);
            #1;
         end
         s_axis_tdata  = b.data;
         s_axis_tkeep  = b.keep;
         s_axis_tlast  = b.last;
         s_axis_tvalid = 1'b1;
         acc = 1'b0;
         t   = 0;
         while (!acc && t < 100) begin
            @(negedge i_clk);
            acc = s_axis_tready;
            @(posedge i_clk);
            #1;
            t++;
         end
         if (acc) n_accepted++;
         check("beat_accepted", {35'b0, acc}, 36'd1);
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic compare_stream(input string tag);
      int s;
      s = 0;
      while (s < got_q.size() && got_q[s] == W_IDLE) s++;
      foreach (exp_q[i])
         check($sformatf("%s[%0d]", tag, i),
               (s + i < got_q.size()) ? got_q[s + i] : 36'bx, exp_q[i]);
   endtask

   task automatic flush_and_clear();
      got_q.delete();
      exp_q.delete();
      beats.delete();
   endtask

   initial begin
      // Reset held three cycles with tvalid already high.
      i_reset       = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'h0302_0100;
      s_axis_tkeep  = 4'hF;
      for (int i = 0; i < 3; i++) begin
         @(posedge i_clk);
         @(negedge i_clk);
         check($sformatf("rst_word%0d", i), {o_xgmii_txc, o_xgmii_txd}, W_IDLE);
         check($sformatf("rst_tready%0d", i), {35'b0, s_axis_tready}, 36'd0);
      end
      got_q.delete();
      i_reset = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      check("start_after_release", {o_xgmii_txc, o_xgmii_txd}, W_START);
      @(posedge i_clk);
      #1;

      // Two 8-byte frames back to back: second Start exactly IPG_WORDS idles after Terminate.
      add_frame(8, 8'h00, 0);
      add_frame(8, 8'h80, 0);
      exp_frame(8, 8'h00);
      exp_frame(8, 8'h80);
      drive_beats();
      repeat (12) @(posedge i_clk);
      #1;
      compare_stream("b2b");

      // 5-byte frame: short tlast beat carries the Terminate (or padding when enabled).
      flush_and_clear();
      add_frame(5, 8'h50, 0);
      exp_frame(5, 8'h50);
      drive_beats();
      repeat (12) @(posedge i_clk);
      #1;
      compare_stream("short5");

      // 64-byte frame with periodic gearbox pauses: same words, stretched.
      flush_and_clear();
      n_accepted = 0;
      pause_en   = 1'b1;
      add_frame(64, 8'hC0, 0);
      exp_frame(64, 8'hC0);
      drive_beats();
      repeat (12) @(posedge i_clk);
      #1;
      pause_en = 1'b0;
      compare_stream("pause64");
      check("pause64_beats", 36'(n_accepted), 36'd16);
      repeat (2) @(posedge i_clk);
      #1;

      // Underflow: tvalid drops after two beats, three more beats drained, then a clean frame.
      flush_and_clear();
      uf_cnt = 0;
      beats.push_back('{32'hA3A2_A1A0, 4'hF, 1'b0, 0});
      beats.push_back('{32'hB3B2_B1B0, 4'hF, 1'b0, 0});
      beats.push_back('{32'hC3C2_C1C0, 4'hF, 1'b0, 1});
      beats.push_back('{32'hD3D2_D1D0, 4'hF, 1'b0, 0});
      beats.push_back('{32'hE3E2_E1E0, 4'hF, 1'b1, 0});
      add_frame(4, 8'h40, 0);
      exp_q.push_back(W_START);
      exp_q.push_back(W_SFD);
      exp_q.push_back({4'h0, 32'hA3A2_A1A0});
      exp_q.push_back({4'h0, 32'hB3B2_B1B0});
      exp_q.push_back(W_ERR);
      repeat (7) exp_q.push_back(W_IDLE);
      exp_frame(4, 8'h40);
      drive_beats();
      repeat (12) @(posedge i_clk);
      #1;
      compare_stream("abort");
      check("abort_underflow_pulses", 36'(uf_cnt), 36'd1);

      // Reset asserted mid-DATA: idle next cycle, then a clean restart.
      flush_and_clear();
      uf_cnt = 0;
      beats.push_back('{32'h1111_1111, 4'hF, 1'b0, 0});
      beats.push_back('{32'h2222_2222, 4'hF, 1'b0, 0});
      drive_beats();
      i_reset = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      check("midrst_word", {o_xgmii_txc, o_xgmii_txd}, W_IDLE);
      check("midrst_tready", {35'b0, s_axis_tready}, 36'd0);
      check("midrst_underflow", {35'b0, o_underflow}, 36'd0);
      i_reset = 1'b0;
      @(posedge i_clk);
      #1;
      flush_and_clear();
      add_frame(12, 8'h60, 0);
      exp_frame(12, 8'h60);
      drive_beats();
      repeat (12) @(posedge i_clk);
      #1;
      compare_stream("after_rst");
      check("after_rst_underflow", 36'(uf_cnt), 36'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
